// File: rtl/id_stage_pkg.sv
// RV32I decode types shared by the ID stage: opcodes, immediate formats, ID/EX record.
package rv32i_types;

    localparam int XLEN = 32;
    localparam int RIDX = 5;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OP_IMM = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111
    } rv32i_opcode;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] rs1_v;
        logic [XLEN-1:0] rs2_v;
        logic [RIDX-1:0] rs1_s;
        logic [RIDX-1:0] rs2_s;
        logic [RIDX-1:0] rd_s;
    } id_ex_stage_t;

    typedef struct packed {
        imm_fmt_t fmt;
        logic     rs1_used;
        logic     rs2_used;
        logic     rd_used;
    } reg_use_t;

    // Unknown opcodes fall to the default: no register traffic, no immediate.
    function automatic reg_use_t decode_use(input logic [6:0] opcode);
        reg_use_t r;
        r = '0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                r.fmt     = IMM_U;
                r.rd_used = 1'b1;
            end
            OPC_JAL: begin
                r.fmt     = IMM_J;
                r.rd_used = 1'b1;
            end
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
                r.fmt      = IMM_I;
                r.rs1_used = 1'b1;
                r.rd_used  = 1'b1;
            end
            OPC_BRANCH: begin
                r.fmt      = IMM_B;
                r.rs1_used = 1'b1;
                r.rs2_used = 1'b1;
            end
            OPC_STORE: begin
                r.fmt      = IMM_S;
                r.rs1_used = 1'b1;
                r.rs2_used = 1'b1;
            end
            OPC_OP: begin
                r.fmt      = IMM_NONE;
                r.rs1_used = 1'b1;
                r.rs2_used = 1'b1;
                r.rd_used  = 1'b1;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// IF/ID, register-file, writeback and ID/EX signals around the decode stage.
interface id_stage_if;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_ready;

    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [31:0] rs1_v;
    logic [31:0] rs2_v;

    logic        wb_we;
    logic [4:0]  wb_rd_s;
    logic [31:0] wb_rd_v;

    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_inst;
    logic [31:0] ex_imm;
    logic [31:0] ex_rs1_v;
    logic [31:0] ex_rs2_v;
    logic [4:0]  ex_rs1_s;
    logic [4:0]  ex_rs2_s;
    logic [4:0]  ex_rd_s;

    modport slave (
        input  id_valid, id_pc, id_inst,
        input  rs1_v, rs2_v,
        input  wb_we, wb_rd_s, wb_rd_v,
        input  flush, ex_ready,
        output id_ready, rs1_s, rs2_s,
        output ex_valid, ex_pc, ex_inst, ex_imm, ex_rs1_v, ex_rs2_v,
        output ex_rs1_s, ex_rs2_s, ex_rd_s
    );

    modport master (
        output id_valid, id_pc, id_inst,
        output rs1_v, rs2_v,
        output wb_we, wb_rd_s, wb_rd_v,
        output flush, ex_ready,
        input  id_ready, rs1_s, rs2_s,
        input  ex_valid, ex_pc, ex_inst, ex_imm, ex_rs1_v, ex_rs2_v,
        input  ex_rs1_s, ex_rs2_s, ex_rd_s
    );
endinterface

// File: rtl/id_stage_imm_gen.sv
// Immediate generator and register-usage decode, purely combinational.
// Latency 0; no flow control.
module imm_gen
    import rv32i_types::*;
(
    input  logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] imm,
    output logic            rs1_used,
    output logic            rs2_used,
    output logic            rd_used
);

    reg_use_t dec_use;

    assign dec_use  = decode_use(inst[6:0]);
    assign rs1_used = dec_use.rs1_used;
    assign rs2_used = dec_use.rs2_used;
    assign rd_used  = dec_use.rd_used;

    always_comb begin
        imm = '0;
        case (dec_use.fmt)
            IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm = {inst[31:12], 12'b0};
            IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: operand bypass, load-use stall and the ID/EX register.
// Latency 1 cycle IF/ID -> ex_valid; EX backpressure or a load-use hazard holds IF/ID.
module id_stage
    import rv32i_types::*;
(
    input  logic      clk,
    input  logic      rst,
    id_stage_if.slave bus
);

    logic [XLEN-1:0] imm_c;
    logic            rs1_used;
    logic            rs2_used;
    logic            rd_used;
    logic [RIDX-1:0] rs1_eff;
    logic [RIDX-1:0] rs2_eff;
    logic [RIDX-1:0] rd_eff;
    logic [XLEN-1:0] rs1_op;
    logic [XLEN-1:0] rs2_op;

    logic            ex_vld_q;
    id_ex_stage_t    ex_q;
    id_ex_stage_t    dec_c;

    logic            ex_load_pending;
    logic            hazard;
    logic            advance;

    imm_gen u_imm_gen (
        .inst     (bus.id_inst),
        .imm      (imm_c),
        .rs1_used (rs1_used),
        .rs2_used (rs2_used),
        .rd_used  (rd_used)
    );

    assign bus.rs1_s = bus.id_inst[19:15];
    assign bus.rs2_s = bus.id_inst[24:20];

    // Unused operand fields are zeroed so they can neither stall nor leak stale data.
    assign rs1_eff = rs1_used ? bus.id_inst[19:15] : '0;
    assign rs2_eff = rs2_used ? bus.id_inst[24:20] : '0;
    assign rd_eff  = rd_used  ? bus.id_inst[11:7]  : '0;

    function automatic logic [XLEN-1:0] operand(
        input logic [RIDX-1:0] rs_s,
        input logic [XLEN-1:0] rf_v,
        input logic            we,
        input logic [RIDX-1:0] wb_s,
        input logic [XLEN-1:0] wb_v
    );
        logic [XLEN-1:0] v;
        if (rs_s == '0)
            v = '0;
        else if (we && (wb_s == rs_s))
            v = wb_v;
        else
            v = rf_v;
        return v;
    endfunction

    assign rs1_op = operand(rs1_eff, bus.rs1_v, bus.wb_we, bus.wb_rd_s, bus.wb_rd_v);
    assign rs2_op = operand(rs2_eff, bus.rs2_v, bus.wb_we, bus.wb_rd_s, bus.wb_rd_v);

    // Only a load still sitting in ID/EX can stall; everything else EX forwards itself.
    assign ex_load_pending = ex_vld_q
                          && (ex_q.inst[6:0] == OPC_LOAD)
                          && (ex_q.rd_s != '0);

    assign hazard = ex_load_pending && bus.id_valid
                 && ((rs1_used && (rs1_eff == ex_q.rd_s))
                  || (rs2_used && (rs2_eff == ex_q.rd_s)));

    assign advance      = !ex_vld_q || bus.ex_ready;
    assign bus.id_ready = bus.flush || (advance && !hazard);

    always_comb begin
        dec_c       = '0;
        dec_c.pc    = bus.id_pc;
        dec_c.inst  = bus.id_inst;
        dec_c.imm   = imm_c;
        dec_c.rs1_v = rs1_op;
        dec_c.rs2_v = rs2_op;
        dec_c.rs1_s = rs1_eff;
        dec_c.rs2_s = rs2_eff;
        dec_c.rd_s  = rd_eff;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_vld_q <= 1'b0;
            ex_q     <= '0;
        end else if (bus.flush) begin
            ex_vld_q <= 1'b0;
        end else if (advance) begin
            if (hazard) begin
                ex_vld_q <= 1'b0;
            end else begin
                ex_vld_q <= bus.id_valid;
                if (bus.id_valid)
                    ex_q <= dec_c;
            end
        end
    end

    assign bus.ex_valid = ex_vld_q;
    assign bus.ex_pc    = ex_q.pc;
    assign bus.ex_inst  = ex_q.inst;
    assign bus.ex_imm   = ex_q.imm;
    assign bus.ex_rs1_v = ex_q.rs1_v;
    assign bus.ex_rs2_v = ex_q.rs2_v;
    assign bus.ex_rs1_s = ex_q.rs1_s;
    assign bus.ex_rs2_s = ex_q.rs2_s;
    assign bus.ex_rd_s  = ex_q.rd_s;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: expected ID/EX records queued at issue, compared when EX consumes.
module tb_id_stage;
    import rv32i_types::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    id_stage_if bus ();

    id_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    id_ex_stage_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] imm,
                            input logic [31:0] r1v, input logic [31:0] r2v,
                            input logic [4:0] r1s, input logic [4:0] r2s, input logic [4:0] rds);
        id_ex_stage_t e;
        e.pc    = pc;
        e.inst  = inst;
        e.imm   = imm;
        e.rs1_v = r1v;
        e.rs2_v = r2v;
        e.rs1_s = r1s;
        e.rs2_s = r2s;
        e.rd_s  = rds;
        exp_q.push_back(e);
    endtask

    // Called mid-cycle: a flushed ID/EX entry is dropped, a consumed one is compared.
    task automatic sb_check();
        id_ex_stage_t e;
        if (bus.ex_valid && bus.flush) begin
            if (exp_q.size() > 0)
                void'(exp_q.pop_front());
        end else if (bus.ex_valid && bus.ex_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_issue", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("ex_pc",    bus.ex_pc,    e.pc);
                chk("ex_inst",  bus.ex_inst,  e.inst);
                chk("ex_imm",   bus.ex_imm,   e.imm);
                chk("ex_rs1_v", bus.ex_rs1_v, e.rs1_v);
                chk("ex_rs2_v", bus.ex_rs2_v, e.rs2_v);
                chk("ex_rs1_s", 32'(bus.ex_rs1_s), 32'(e.rs1_s));
                chk("ex_rs2_s", 32'(bus.ex_rs2_s), 32'(e.rs2_s));
                chk("ex_rd_s",  32'(bus.ex_rd_s),  32'(e.rd_s));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sb_check();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic [31:0] r1, input logic [31:0] r2);
        bus.id_valid = v;
        bus.id_pc    = pc;
        bus.id_inst  = inst;
        bus.rs1_v    = r1;
        bus.rs2_v    = r2;
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        bus.id_valid = 1'b0;
        bus.id_pc    = '0;
        bus.id_inst  = '0;
        bus.rs1_v    = '0;
        bus.rs2_v    = '0;
        bus.wb_we    = 1'b0;
        bus.wb_rd_s  = '0;
        bus.wb_rd_v  = '0;
        bus.flush    = 1'b0;
        bus.ex_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("rst_ex_pc",    bus.ex_pc,   32'd0);
        chk("rst_ex_inst",  bus.ex_inst, 32'd0);
        chk("rst_ex_imm",   bus.ex_imm,  32'd0);
        chk("rst_ex_rd_s",  32'(bus.ex_rd_s), 32'd0);

        // ADDI x1,x0,5: x0 reads 0 despite rs1_v, unused rs2 field reads as 0
        drive(1'b1, 32'h100, 32'h00500093, 32'h11, 32'h0);
        chk("rs1_s_comb", 32'(bus.rs1_s), 32'd0);
        chk("rs2_s_comb", 32'(bus.rs2_s), 32'd5);
        chk("addi_rdy", 32'(bus.id_ready), 32'd1);
        push_exp(32'h100, 32'h00500093, 32'd5, 32'h0, 32'h0, 5'd0, 5'd0, 5'd1);
        tick();
        chk("addi_valid", 32'(bus.ex_valid), 32'd1);

        // ADD x3,x2,x2 with same-cycle writeback to x2
        bus.wb_we   = 1'b1;
        bus.wb_rd_s = 5'd2;
        bus.wb_rd_v = 32'hAB;
        drive(1'b1, 32'h104, 32'h002101B3, 32'h11, 32'h11);
        chk("add_rs1_s_comb", 32'(bus.rs1_s), 32'd2);
        chk("add_byp_rdy", 32'(bus.id_ready), 32'd1);
        push_exp(32'h104, 32'h002101B3, 32'd0, 32'hAB, 32'hAB, 5'd2, 5'd2, 5'd3);
        tick();

        // writeback to x0 must not bypass
        bus.wb_rd_s = 5'd0;
        drive(1'b1, 32'h108, 32'h002101B3, 32'h11, 32'h11);
        push_exp(32'h108, 32'h002101B3, 32'd0, 32'h11, 32'h11, 5'd2, 5'd2, 5'd3);
        tick();
        bus.wb_we = 1'b0;

        // LW x5,0(x1) then dependent ADD x6,x5,x0: one bubble
        drive(1'b1, 32'h10C, 32'h0000A283, 32'h1000, 32'h0);
        push_exp(32'h10C, 32'h0000A283, 32'd0, 32'h1000, 32'h0, 5'd1, 5'd0, 5'd5);
        tick();
        drive(1'b1, 32'h110, 32'h00028333, 32'h55, 32'h66);
        chk("lu_stall_rdy", 32'(bus.id_ready), 32'd0);
        tick();
        chk("lu_bubble", 32'(bus.ex_valid), 32'd0);
        chk("lu_retry_rdy", 32'(bus.id_ready), 32'd1);
        push_exp(32'h110, 32'h00028333, 32'd0, 32'h55, 32'h0, 5'd5, 5'd0, 5'd6);
        tick();
        chk("lu_issue", 32'(bus.ex_valid), 32'd1);

        // LW then independent ADD x6,x7,x0: no bubble
        drive(1'b1, 32'h114, 32'h0000A283, 32'h1000, 32'h0);
        push_exp(32'h114, 32'h0000A283, 32'd0, 32'h1000, 32'h0, 5'd1, 5'd0, 5'd5);
        tick();
        drive(1'b1, 32'h118, 32'h00038333, 32'h77, 32'h66);
        chk("nolu_rdy", 32'(bus.id_ready), 32'd1);
        push_exp(32'h118, 32'h00038333, 32'd0, 32'h77, 32'h0, 5'd7, 5'd0, 5'd6);
        tick();
        chk("nolu_valid", 32'(bus.ex_valid), 32'd1);

        // immediates: BEQ -4, JAL +2048, LUI 0x12345, illegal opcode
        drive(1'b1, 32'h11C, 32'hFE000EE3, 32'h11, 32'h22);
        push_exp(32'h11C, 32'hFE000EE3, 32'hFFFFFFFC, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        tick();
        drive(1'b1, 32'h120, 32'h001000EF, 32'h0, 32'h0);
        push_exp(32'h120, 32'h001000EF, 32'h00000800, 32'h0, 32'h0, 5'd0, 5'd0, 5'd1);
        tick();
        drive(1'b1, 32'h124, 32'h12345237, 32'h0, 32'h0);
        push_exp(32'h124, 32'h12345237, 32'h12345000, 32'h0, 32'h0, 5'd0, 5'd0, 5'd4);
        tick();
        drive(1'b1, 32'h128, 32'hFFFFFFFF, 32'h0, 32'h0);
        push_exp(32'h128, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        tick();

        // EX backpressure for 3 cycles: ID/EX and IF/ID held
        bus.ex_ready = 1'b0;
        drive(1'b1, 32'h12C, 32'h00500093, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_rdy",   32'(bus.id_ready), 32'd0);
            chk("bp_valid", 32'(bus.ex_valid), 32'd1);
            chk("bp_pc",    bus.ex_pc,   32'h128);
            chk("bp_inst",  bus.ex_inst, 32'hFFFFFFFF);
            chk("bp_imm",   bus.ex_imm,  32'h0);
            tick();
        end
        bus.ex_ready = 1'b1;
        #1;
        chk("bp_release_rdy", 32'(bus.id_ready), 32'd1);
        push_exp(32'h12C, 32'h00500093, 32'd5, 32'h0, 32'h0, 5'd0, 5'd0, 5'd1);
        tick();
        chk("bp_release_pc", bus.ex_pc, 32'h12C);

        // flush during a load-use stall
        drive(1'b1, 32'h130, 32'h0000A283, 32'h1000, 32'h0);
        push_exp(32'h130, 32'h0000A283, 32'd0, 32'h1000, 32'h0, 5'd1, 5'd0, 5'd5);
        tick();
        drive(1'b1, 32'h134, 32'h00028333, 32'h55, 32'h0);
        chk("fl_stall_rdy", 32'(bus.id_ready), 32'd0);
        bus.flush = 1'b1;
        #1;
        chk("fl_rdy", 32'(bus.id_ready), 32'd1);
        tick();
        bus.flush = 1'b0;
        chk("fl_killed", 32'(bus.ex_valid), 32'd0);
        drive(1'b1, 32'h200, 32'h00700113, 32'h11, 32'h0);
        chk("fl_next_rdy", 32'(bus.id_ready), 32'd1);
        push_exp(32'h200, 32'h00700113, 32'd7, 32'h0, 32'h0, 5'd0, 5'd0, 5'd2);
        tick();
        chk("fl_next_valid", 32'(bus.ex_valid), 32'd1);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        chk("idle_valid", 32'(bus.ex_valid), 32'd0);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
